// File: rtl/accel_mmap_regs.sv
// Memory-mapped register slave for the accelerator core: address windows, start handshake, status flags.
// Optional: define ACCEL_MMAP_STICKY_FLAGS_EN to make the two "full" flags sticky until read.
module accel_mmap_regs #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_wr_en,
  input  logic              bus_rd_en,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic              bus_err,
  input  logic              input_buff_full,
  input  logic              input_buff_empty,
  input  logic              output_buff_full,
  input  logic              output_buff_empty,
  output logic              core_start,
  input  logic              core_done,
  output logic [DATA_W-1:0] preproc_start_addr,
  output logic [DATA_W-1:0] preproc_end_addr,
  output logic [DATA_W-1:0] postproc_start_addr,
  output logic [DATA_W-1:0] postproc_end_addr
);

  typedef enum logic [ADDR_W-1:0] {
    START_ACCEL         = ADDR_W'(4'd0),
    PREPROC_START_ADDR  = ADDR_W'(4'd1),
    PREPROC_END_ADDR    = ADDR_W'(4'd2),
    POSTPROC_START_ADDR = ADDR_W'(4'd3),
    POSTPROC_END_ADDR   = ADDR_W'(4'd4),
    RD_ONLY             = ADDR_W'(4'd5),
    INPUT_BUFF_FULL     = ADDR_W'(4'd6),
    INPUT_BUFF_EMPTY    = ADDR_W'(4'd7),
    OUTPUT_BUFF_FULL    = ADDR_W'(4'd8),
    OUTPUT_BUFF_EMPTY   = ADDR_W'(4'd9)
  } mmap_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e            r_state;
  logic              r_core_start;
  logic [DATA_W-1:0] r_pre_start, r_pre_end, r_post_start, r_post_end;
  logic [3:0]        r_flags;   // {out_empty, out_full, in_empty, in_full}
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid, r_err;

  logic              w_both, w_rd, w_wr, w_idle, w_is_areg;
  logic              w_start_req, w_wr_reg, w_rd_err, w_wr_err, w_err;
  logic [DATA_W-1:0] w_rd_data;

  // Access decode: qualify strobes, select read data and classify errors.
  always_comb begin
    w_both      = bus_wr_en & bus_rd_en;
    w_rd        = bus_rd_en & ~bus_wr_en;
    w_wr        = bus_wr_en & ~bus_rd_en;
    w_idle      = (r_state == ST_IDLE);
    w_is_areg   = (bus_addr >= PREPROC_START_ADDR) && (bus_addr <= POSTPROC_END_ADDR);
    w_start_req = w_wr && (bus_addr == START_ACCEL) && bus_wdata[0] && w_idle;
    w_wr_reg    = w_wr && w_is_areg && w_idle;
    w_rd_data   = '0;
    w_rd_err    = 1'b0;
    if (w_rd) begin
      case (bus_addr)
        START_ACCEL:         w_rd_data = {{(DATA_W-1){1'b0}}, ~w_idle};
        PREPROC_START_ADDR:  w_rd_data = r_pre_start;
        PREPROC_END_ADDR:    w_rd_data = r_pre_end;
        POSTPROC_START_ADDR: w_rd_data = r_post_start;
        POSTPROC_END_ADDR:   w_rd_data = r_post_end;
        INPUT_BUFF_FULL:     w_rd_data = {{(DATA_W-1){1'b0}}, r_flags[0]};
        INPUT_BUFF_EMPTY:    w_rd_data = {{(DATA_W-1){1'b0}}, r_flags[1]};
        OUTPUT_BUFF_FULL:    w_rd_data = {{(DATA_W-1){1'b0}}, r_flags[2]};
        OUTPUT_BUFF_EMPTY:   w_rd_data = {{(DATA_W-1){1'b0}}, r_flags[3]};
        default:             w_rd_err  = 1'b1;
      endcase
    end else begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
    end
    if (w_wr) begin
      if (bus_addr == START_ACCEL) begin
        w_wr_err = bus_wdata[0] & ~w_idle;
      end else if (w_is_areg) begin
        w_wr_err = ~w_idle;
      end else begin
        w_wr_err = 1'b1;
      end
    end else begin
      w_wr_err = 1'b0;
    end
    w_err = w_both | w_rd_err | w_wr_err;
  end

  // Start handshake FSM; core_start is high exactly while in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_core_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_req) begin
            r_state      <= ST_START;
            r_core_start <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_core_start <= 1'b0;
          end
        end
        ST_START: begin
          r_state      <= ST_BUSY;
          r_core_start <= 1'b0;
        end
        ST_BUSY: begin
          r_state      <= core_done ? ST_IDLE : ST_BUSY;
          r_core_start <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_core_start <= 1'b0;
        end
      endcase
    end
  end

  // Address window registers, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_start  <= '0;
      r_pre_end    <= '0;
      r_post_start <= '0;
      r_post_end   <= '0;
    end else if (w_wr_reg) begin
      case (bus_addr)
        PREPROC_START_ADDR:  r_pre_start  <= bus_wdata;
        PREPROC_END_ADDR:    r_pre_end    <= bus_wdata;
        POSTPROC_START_ADDR: r_post_start <= bus_wdata;
        POSTPROC_END_ADDR:   r_post_end   <= bus_wdata;
        default:             r_pre_start  <= r_pre_start;
      endcase
    end
  end

  // Status flag sampling; sticky full flags clear on a read of their own register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'd0;
    end else begin
`ifdef ACCEL_MMAP_STICKY_FLAGS_EN
      r_flags[0] <= input_buff_full  | (r_flags[0] & ~(w_rd && (bus_addr == INPUT_BUFF_FULL)));
      r_flags[2] <= output_buff_full | (r_flags[2] & ~(w_rd && (bus_addr == OUTPUT_BUFF_FULL)));
`else
      r_flags[0] <= input_buff_full;
      r_flags[2] <= output_buff_full;
`endif
      r_flags[1] <= input_buff_empty;
      r_flags[3] <= output_buff_empty;
    end
  end

  // One-cycle read/error response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd | w_both;
      r_rdata  <= w_rd_data;
      r_err    <= w_err;
    end
  end

  assign bus_rdata           = r_rdata;
  assign bus_rvalid          = r_rvalid;
  assign bus_err             = r_err;
  assign core_start          = r_core_start;
  assign preproc_start_addr  = r_pre_start;
  assign preproc_end_addr    = r_pre_end;
  assign postproc_start_addr = r_post_start;
  assign postproc_end_addr   = r_post_end;

endmodule
